// File: rtl/imm_extend_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imm_extend_pipe_pkg
//  Description : Shared constants for the immediate generator: LEGv8 opcode
//                patterns with their don't-care masks, format codes, and
//                default widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package imm_extend_pipe_pkg;

  localparam int DEF_WORD      = 64;
  localparam int DEF_INSTR_LEN = 32;

  // Format codes presented on out_fmt
  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_D    = 3'd1;
  localparam logic [2:0] FMT_CB   = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_I    = 3'd4;
  localparam logic [2:0] FMT_IW   = 3'd5;

  // Opcode patterns on instr[31:21]; a 0 in the mask marks a don't-care bit
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] MSK_D   = 11'b11111111111;

  localparam logic [10:0] OP_CBZ  = 11'b10110100000;
  localparam logic [10:0] OP_CBNZ = 11'b10110101000;
  localparam logic [10:0] MSK_CB  = 11'b11111111000;

  localparam logic [10:0] OP_B    = 11'b00010100000;
  localparam logic [10:0] OP_BL   = 11'b10010100000;
  localparam logic [10:0] MSK_B   = 11'b11111100000;

  localparam logic [10:0] OP_ADDI = 11'b10010001000;
  localparam logic [10:0] OP_SUBI = 11'b11010001000;
  localparam logic [10:0] MSK_I   = 11'b11111111110;

  localparam logic [10:0] OP_MOVZ = 11'b11010010100;
  localparam logic [10:0] OP_MOVK = 11'b11110010100;
  localparam logic [10:0] MSK_IW  = 11'b11111111100;

  // True when the opcode equals the pattern on every cared-about bit
  function automatic logic op_match(input logic [10:0] op,
                                    input logic [10:0] pat,
                                    input logic [10:0] msk);
    return ((op & msk) == (pat & msk));
  endfunction

endpackage
`default_nettype wire

// File: rtl/imm_format_decode.sv
`default_nettype none
// ============================================================================
//  Module      : imm_format_decode
//  Description : Combinational LEGv8 format classifier and immediate
//                extender. All extension is done at full WORD width.
//  Revision    : 1.0 - initial release
// ============================================================================
module imm_format_decode
  import imm_extend_pipe_pkg::*;
#(
  parameter int WORD         = DEF_WORD,
  parameter int INSTR_LEN    = DEF_INSTR_LEN,
  parameter int SHIFT_BRANCH = 1
) (
  input  logic [INSTR_LEN-1:0] instr_i,
  output logic [2:0]           fmt_o,
  output logic                 illegal_o,
  output logic [WORD-1:0]      imm_o
);

  // A 32-bit datapath cannot hold a move-wide halfword at position 2 or 3
  localparam bit NARROW = (WORD == 32);

  logic [10:0]     w_op;
  logic [1:0]      w_hw;
  logic [WORD-1:0] w_d_imm;
  logic [WORD-1:0] w_cb_sext;
  logic [WORD-1:0] w_b_sext;
  logic [WORD-1:0] w_cb_imm;
  logic [WORD-1:0] w_b_imm;
  logic [WORD-1:0] w_i_imm;
  logic [WORD-1:0] w_iw_base;
  logic [WORD-1:0] w_iw_imm;

  assign w_op      = instr_i[31:21];
  assign w_hw      = instr_i[22:21];
  assign w_d_imm   = {{(WORD-9){instr_i[20]}},  instr_i[20:12]};
  assign w_cb_sext = {{(WORD-19){instr_i[23]}}, instr_i[23:5]};
  assign w_b_sext  = {{(WORD-26){instr_i[25]}}, instr_i[25:0]};
  assign w_i_imm   = {{(WORD-12){1'b0}},        instr_i[21:10]};
  assign w_iw_base = {{(WORD-16){1'b0}},        instr_i[20:5]};
  assign w_iw_imm  = w_iw_base << {w_hw, 4'b0000};

  // Branch offsets are word offsets; scaling drops any bits shifted past WORD
  generate
    if (SHIFT_BRANCH != 0) begin : g_branch_scaled
      assign w_cb_imm = w_cb_sext << 2;
      assign w_b_imm  = w_b_sext << 2;
    end else begin : g_branch_unscaled
      assign w_cb_imm = w_cb_sext;
      assign w_b_imm  = w_b_sext;
    end
  endgenerate

  // Classify the opcode and select the matching immediate; unknown -> illegal
  always_comb begin
    fmt_o     = FMT_NONE;
    illegal_o = 1'b1;
    imm_o     = '0;
    if (op_match(w_op, OP_LDUR, MSK_D) || op_match(w_op, OP_STUR, MSK_D)) begin
      fmt_o     = FMT_D;
      illegal_o = 1'b0;
      imm_o     = w_d_imm;
    end else if (op_match(w_op, OP_CBZ, MSK_CB) || op_match(w_op, OP_CBNZ, MSK_CB)) begin
      fmt_o     = FMT_CB;
      illegal_o = 1'b0;
      imm_o     = w_cb_imm;
    end else if (op_match(w_op, OP_B, MSK_B) || op_match(w_op, OP_BL, MSK_B)) begin
      fmt_o     = FMT_B;
      illegal_o = 1'b0;
      imm_o     = w_b_imm;
    end else if (op_match(w_op, OP_ADDI, MSK_I) || op_match(w_op, OP_SUBI, MSK_I)) begin
      fmt_o     = FMT_I;
      illegal_o = 1'b0;
      imm_o     = w_i_imm;
    end else if (op_match(w_op, OP_MOVZ, MSK_IW) || op_match(w_op, OP_MOVK, MSK_IW)) begin
      fmt_o = FMT_IW;
      if (NARROW && w_hw[1]) begin
        illegal_o = 1'b1;
        imm_o     = '0;
      end else begin
        illegal_o = 1'b0;
        imm_o     = w_iw_imm;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/imm_extend_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : imm_extend_pipe
//  Description : Registered immediate generator. Decodes each accepted
//                instruction and queues {imm, fmt, illegal, tag} in a
//                2-entry skid buffer with valid/ready on both sides.
//  Revision    : 1.0 - initial release
// ============================================================================
module imm_extend_pipe
  import imm_extend_pipe_pkg::*;
#(
  parameter int WORD         = DEF_WORD,
  parameter int INSTR_LEN    = DEF_INSTR_LEN,
  parameter int TAG_W        = 64,
  parameter int SHIFT_BRANCH = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [INSTR_LEN-1:0] in_instr,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD-1:0]      out_imm,
  output logic [2:0]           out_fmt,
  output logic                 out_illegal,
  output logic [TAG_W-1:0]     out_tag
);

  localparam int DEPTH = 2;

  logic [WORD-1:0]  imm_q [DEPTH];
  logic [2:0]       fmt_q [DEPTH];
  logic             ill_q [DEPTH];
  logic [TAG_W-1:0] tag_q [DEPTH];

  logic [1:0] count_q, count_d;
  logic       head_q,  head_d;

  logic [WORD-1:0] w_dec_imm;
  logic [2:0]      w_dec_fmt;
  logic            w_dec_ill;
  logic            w_push;
  logic            w_pop;
  logic            w_wr_ptr;

  imm_format_decode #(
    .WORD         (WORD),
    .INSTR_LEN    (INSTR_LEN),
    .SHIFT_BRANCH (SHIFT_BRANCH)
  ) u_decode (
    .instr_i   (in_instr),
    .fmt_o     (w_dec_fmt),
    .illegal_o (w_dec_ill),
    .imm_o     (w_dec_imm)
  );

  // Ready looks only at the registered count so there is no path from out_ready
  assign in_ready  = ~reset & ~count_q[1];
  assign out_valid = |count_q;
  assign w_push    = in_valid & in_ready & ~flush;
  assign w_pop     = out_valid & out_ready;
  // Tail slot sits one past head when a single entry is held
  assign w_wr_ptr  = head_q ^ count_q[0];

  assign out_imm     = imm_q[head_q];
  assign out_fmt     = fmt_q[head_q];
  assign out_illegal = ill_q[head_q];
  assign out_tag     = tag_q[head_q];

  // Occupancy and head pointer update; flush empties the buffer and wins over push
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      if (w_pop) begin
        head_d = ~head_q;
      end
      case ({w_push, w_pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= 2'd0;
      head_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
    end
  end

  // Payload storage: decoded result lands in the tail slot on each accepted push
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        imm_q[i] <= '0;
        fmt_q[i] <= FMT_NONE;
        ill_q[i] <= 1'b0;
        tag_q[i] <= '0;
      end
    end else if (w_push) begin
      imm_q[w_wr_ptr] <= w_dec_imm;
      fmt_q[w_wr_ptr] <= w_dec_fmt;
      ill_q[w_wr_ptr] <= w_dec_ill;
      tag_q[w_wr_ptr] <= in_tag;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imm_extend_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imm_extend_pipe
//  Description : Scoreboard bench for imm_extend_pipe, running a 64-bit and
//                a 32-bit build side by side on identical stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_extend_pipe;

  localparam int NV = 16;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] in_instr;
  logic [63:0] in_tag;

  logic        in_ready, out_valid, out_illegal;
  logic [63:0] out_imm, out_tag;
  logic [2:0]  out_fmt;

  logic        in_ready32, out_valid32, out_illegal32;
  logic [31:0] out_imm32;
  logic [63:0] out_tag32;
  logic [2:0]  out_fmt32;

  typedef struct {
    logic [63:0] imm64;
    logic [31:0] imm32;
    logic [2:0]  fmt;
    logic        ill64;
    logic        ill32;
    logic [63:0] tag;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  logic [31:0] v_instr [NV];
  logic [63:0] v_imm   [NV];
  logic [2:0]  v_fmt   [NV];
  logic        v_ill   [NV];
  logic        v_ill32 [NV];

  int n_cmp = 0;
  int n_err = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  imm_extend_pipe #(.WORD(64), .INSTR_LEN(32), .TAG_W(64), .SHIFT_BRANCH(1)) u_dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_imm(out_imm), .out_fmt(out_fmt), .out_illegal(out_illegal), .out_tag(out_tag)
  );

  imm_extend_pipe #(.WORD(32), .INSTR_LEN(32), .TAG_W(64), .SHIFT_BRANCH(1)) u_dut32 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid32), .out_ready(out_ready),
    .out_imm(out_imm32), .out_fmt(out_fmt32), .out_illegal(out_illegal32), .out_tag(out_tag32)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic set_vec(input int i, input logic [31:0] instr, input logic [2:0] fmt,
                         input logic ill, input logic [63:0] imm, input logic ill32);
    v_instr[i] = instr;
    v_fmt[i]   = fmt;
    v_ill[i]   = ill;
    v_imm[i]   = imm;
    v_ill32[i] = ill32;
  endtask

  // Drive one instruction until accepted; expectation is queued at the accepting edge
  task automatic push(input int idx, input logic [63:0] tag);
    exp_t e;
    bit   done;
    done    = 1'b0;
    e.imm64 = v_imm[idx];
    e.fmt   = v_fmt[idx];
    e.ill64 = v_ill[idx];
    e.ill32 = v_ill32[idx];
    e.imm32 = v_ill32[idx] ? 32'h0 : v_imm[idx][31:0];
    e.tag   = tag;
    in_valid = 1'b1;
    in_instr = v_instr[idx];
    in_tag   = tag;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(e);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) check("push_timeout", 64'd1, 64'd0);
  endtask

  task automatic drain();
    for (int c = 0; c < 60 && sb.size() != 0; c++) @(posedge clk);
    #1;
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  // Compare the head of both DUTs against the scoreboard front; pop on transfer
  always @(negedge clk) begin
    if (mon_en) begin
      check("valid_w32", {63'd0, out_valid32}, {63'd0, out_valid});
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_out", 64'd1, 64'd0);
        end else begin
          mon_e = sb[0];
          check("imm",       out_imm,                  mon_e.imm64);
          check("fmt",       {61'd0, out_fmt},         {61'd0, mon_e.fmt});
          check("illegal",   {63'd0, out_illegal},     {63'd0, mon_e.ill64});
          check("tag",       out_tag,                  mon_e.tag);
          check("imm_w32",   {32'd0, out_imm32},       {32'd0, mon_e.imm32});
          check("fmt_w32",   {61'd0, out_fmt32},       {61'd0, mon_e.fmt});
          check("ill_w32",   {63'd0, out_illegal32},   {63'd0, mon_e.ill32});
          check("tag_w32",   out_tag32,                mon_e.tag);
          if (out_ready) mon_e = sb.pop_front();
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = 32'h0; in_tag = 64'h0;

    //          idx instr          fmt  ill  imm64                   ill32
    set_vec( 0, 32'hF85FF041, 3'd1, 1'b0, 64'hFFFFFFFF_FFFFFFFF, 1'b0); // LDUR -1
    set_vec( 1, 32'hF80FF000, 3'd1, 1'b0, 64'h00000000_000000FF, 1'b0); // STUR +255
    set_vec( 2, 32'hB4FFFFC0, 3'd2, 1'b0, 64'hFFFFFFFF_FFFFFFF8, 1'b0); // CBZ -2 <<2
    set_vec( 3, 32'hB5000060, 3'd2, 1'b0, 64'h00000000_0000000C, 1'b0); // CBNZ 3 <<2
    set_vec( 4, 32'h14000010, 3'd3, 1'b0, 64'h00000000_00000040, 1'b0); // B 16 <<2
    set_vec( 5, 32'h97FFFFFF, 3'd3, 1'b0, 64'hFFFFFFFF_FFFFFFFC, 1'b0); // BL -1 <<2
    set_vec( 6, 32'h91003C20, 3'd4, 1'b0, 64'h00000000_0000000F, 1'b0); // ADDI 15
    set_vec( 7, 32'hD13FFC00, 3'd4, 1'b0, 64'h00000000_00000FFF, 1'b0); // SUBI 4095
    set_vec( 8, 32'hD2D7DDE3, 3'd5, 1'b0, 64'h0000BEEF_00000000, 1'b1); // MOVZ hw=2
    set_vec( 9, 32'hF2A24680, 3'd5, 1'b0, 64'h00000000_12340000, 1'b0); // MOVK hw=1
    set_vec(10, 32'hD2FFFFE0, 3'd5, 1'b0, 64'hFFFF0000_00000000, 1'b1); // MOVZ hw=3
    set_vec(11, 32'hD2801560, 3'd5, 1'b0, 64'h00000000_000000AB, 1'b0); // MOVZ hw=0
    set_vec(12, 32'h00000000, 3'd0, 1'b1, 64'h0,                 1'b1); // no match
    set_vec(13, 32'hF8200000, 3'd0, 1'b1, 64'h0,                 1'b1); // near-miss of LDUR
    set_vec(14, 32'h8B000000, 3'd0, 1'b1, 64'h0,                 1'b1); // register ADD
    set_vec(15, 32'h15FFFFFF, 3'd3, 1'b0, 64'h00000000_07FFFFFC, 1'b0); // B max positive

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {63'd0, out_valid},   64'd0);
    check("rst_in_ready",  {63'd0, in_ready},    64'd0);
    check("rst_imm",       out_imm,              64'd0);
    check("rst_fmt",       {61'd0, out_fmt},     64'd0);
    check("rst_illegal",   {63'd0, out_illegal}, 64'd0);
    check("rst_tag",       out_tag,              64'd0);
    check("rst_in_ready32",{63'd0, in_ready32},  64'd0);
    reset = 1'b0;
    #1;
    check("ready_after_rst", {63'd0, in_ready}, 64'd1);
    mon_en = 1'b1;

    // Every format, consumer always ready, back-to-back
    out_ready = 1'b1;
    for (int i = 0; i < NV; i++) push(i, 64'h1000 + 64'(i) * 4);
    drain();

    // Random consumer backpressure against a steady producer
    fork
      begin
        for (int k = 0; k < 30; k++) push(k % NV, 64'h2000 + 64'(k));
      end
      begin
        for (int k = 0; k < 80; k++) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    drain();

    // Fill to two with consumer stalled; third held until space frees
    out_ready = 1'b0;
    push(0, 64'hA);
    push(4, 64'hB);
    in_valid = 1'b1;
    in_instr = v_instr[6];
    in_tag   = 64'hC;
    @(negedge clk);
    check("full_in_ready", {63'd0, in_ready},  64'd0);
    check("full_valid",    {63'd0, out_valid}, 64'd1);
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b1;
    push(6, 64'hC);
    drain();

    // Flush with two entries held and a pending input
    out_ready = 1'b0;
    push(2, 64'h31);
    push(3, 64'h32);
    in_valid = 1'b1;
    in_instr = v_instr[5];
    in_tag   = 64'h33;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    check("flush2_valid", {63'd0, out_valid}, 64'd0);
    check("flush2_ready", {63'd0, in_ready},  64'd1);

    // Flush with one entry held while a push would otherwise be accepted
    @(posedge clk);
    #1;
    push(7, 64'h41);
    in_valid = 1'b1;
    in_instr = v_instr[8];
    in_tag   = 64'h42;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    check("flush1_valid", {63'd0, out_valid}, 64'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    push(9, 64'h43);
    drain();

    // Asynchronous reset in the middle of a cycle
    out_ready = 1'b0;
    push(10, 64'h51);
    push(11, 64'h52);
    #2;
    reset = 1'b1;
    sb.delete();
    #1;
    check("async_rst_valid", {63'd0, out_valid}, 64'd0);
    check("async_rst_ready", {63'd0, in_ready},  64'd0);
    check("async_rst_tag",   out_tag,            64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_valid", {63'd0, out_valid}, 64'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    push(15, 64'h53);
    push(12, 64'h54);
    drain();

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
